// File: rtl/song_sequencer.sv
// ============================================================================
//  Module      : song_sequencer
//  Description : Play/pause/stop sequencer that walks a 4-bit song ROM at a
//                fixed sample rate derived from clk50Mghz. It emits one
//                registered sample per tick. At the end of the song it either
//                loops back to address 0 or parks in DONE.
//  Ports       : clk50Mghz    - sole clock, rising edge
//                rst          - synchronous active-high reset
//                play         - start (IDLE/DONE) or resume (PAUSED)
//                pause        - suspend playback, keep position
//                stop         - abort playback, rewind to address 0
//                loop_en      - restart at address 0 after the last sample
//                rom_addr     - registered song ROM address
//                rom_data     - combinational ROM data for rom_addr
//                sample_out   - registered audio sample
//                sample_valid - one-cycle pulse when sample_out updates
//                state        - IDLE=0, PLAYING=1, PAUSED=2, DONE=3
//                song_end     - one-cycle pulse with the final sample
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module song_sequencer #(
    parameter int SAMPLE_DIV = 6250,
    parameter int SONG_LAST  = 25629
) (
    input  logic        clk50Mghz,
    input  logic        rst,
    input  logic        play,
    input  logic        pause,
    input  logic        stop,
    input  logic        loop_en,
    output logic [14:0] rom_addr,
    input  logic [3:0]  rom_data,
    output logic [3:0]  sample_out,
    output logic        sample_valid,
    output logic [1:0]  state,
    output logic        song_end
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAYING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // 16 bits covers the whole legal divider range (up to 65535).
    localparam logic [15:0] c_DIV_LAST  = 16'(SAMPLE_DIV - 1);
    localparam logic [14:0] c_SONG_LAST = 15'(SONG_LAST);

    state_t      r_state;
    logic [15:0] r_tick_cnt;
    logic [14:0] r_addr;
    logic [3:0]  r_sample;
    logic        r_valid;
    logic        r_end;

    logic        w_cnt_full;
    logic        w_at_last;

    // Stop and pause have priority in the sequential block, so this only
    // turns into a real tick when neither command is asserted.
    assign w_cnt_full = (r_state == ST_PLAYING) && (r_tick_cnt == c_DIV_LAST);
    assign w_at_last  = (r_addr == c_SONG_LAST);

    always_ff @(posedge clk50Mghz) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_tick_cnt <= 16'd0;
            r_addr     <= 15'd0;
            r_sample   <= 4'd0;
            r_valid    <= 1'b0;
            r_end      <= 1'b0;
        end else begin
            // Pulses default low and are raised only on a tick.
            r_valid <= 1'b0;
            r_end   <= 1'b0;

            if (stop) begin
                r_state    <= ST_IDLE;
                r_tick_cnt <= 16'd0;
                r_addr     <= 15'd0;
                r_sample   <= 4'd0;
            end else if (pause) begin
                // Counter and address freeze, so a tick that pause
                // suppresses fires on the first cycle after resume.
                if (r_state == ST_PLAYING) begin
                    r_state <= ST_PAUSED;
                end
            end else if (play && (r_state == ST_IDLE || r_state == ST_DONE)) begin
                r_state    <= ST_PLAYING;
                r_tick_cnt <= 16'd0;
                r_addr     <= 15'd0;
            end else if (play && (r_state == ST_PAUSED)) begin
                r_state <= ST_PLAYING;
            end else if (r_state == ST_PLAYING) begin
                if (w_cnt_full) begin
                    r_tick_cnt <= 16'd0;
                    r_sample   <= rom_data;
                    r_valid    <= 1'b1;
                    if (w_at_last) begin
                        r_end  <= 1'b1;
                        r_addr <= 15'd0;
                        if (!loop_en) begin
                            r_state <= ST_DONE;
                        end
                    end else begin
                        r_addr <= r_addr + 15'd1;
                    end
                end else begin
                    r_tick_cnt <= r_tick_cnt + 16'd1;
                end
            end
        end
    end

    assign rom_addr     = r_addr;
    assign sample_out   = r_sample;
    assign sample_valid = r_valid;
    assign state        = r_state;
    assign song_end     = r_end;

endmodule

`default_nettype wire

// File: tb/tb_song_sequencer.sv
// ============================================================================
//  Module      : tb_song_sequencer
//  Description : Self-checking bench for song_sequencer. It runs directed
//                scenarios and a random command soak against a cycle-count
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_song_sequencer;

    localparam int c_DIV  = 4;
    localparam int c_LAST = 7;

    logic        clk = 1'b0;
    logic        rst, play, pause, stop, loop_en;
    logic [14:0] rom_addr;
    logic [3:0]  rom_data;
    logic [3:0]  sample_out;
    logic        sample_valid;
    logic [1:0]  state;
    logic        song_end;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign rom_data = rom_addr[3:0] ^ 4'hA;

    song_sequencer #(
        .SAMPLE_DIV (c_DIV),
        .SONG_LAST  (c_LAST)
    ) dut (
        .clk50Mghz    (clk),
        .rst          (rst),
        .play         (play),
        .pause        (pause),
        .stop         (stop),
        .loop_en      (loop_en),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .state        (state),
        .song_end     (song_end)
    );

    // Reference model. Song position plus "cycles left until the next sample".
    logic [1:0]  m_state;
    logic [14:0] m_addr;
    logic [3:0]  m_sample;
    logic        m_valid;
    logic        m_end;
    int          m_rem;

    logic [3:0] exp_seq [8] = '{4'hA, 4'hB, 4'h8, 4'h9, 4'hE, 4'hF, 4'hC, 4'hD};

    function automatic logic [3:0] rom_fn(input logic [14:0] a);
        return a[3:0] ^ 4'hA;
    endfunction

    task automatic model_step(input logic r, pl, pa, st, lp);
        m_valid = 1'b0;
        m_end   = 1'b0;
        if (r || st) begin
            m_state = 2'd0; m_addr = 15'd0; m_sample = 4'd0; m_rem = c_DIV;
        end else if (pa) begin
            if (m_state == 2'd1) m_state = 2'd2;
        end else if (pl && (m_state == 2'd0 || m_state == 2'd3)) begin
            m_state = 2'd1; m_addr = 15'd0; m_rem = c_DIV;
        end else if (pl && m_state == 2'd2) begin
            m_state = 2'd1;
        end else if (m_state == 2'd1) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                m_rem    = c_DIV;
                m_sample = rom_fn(m_addr);
                m_valid  = 1'b1;
                if (int'(m_addr) == c_LAST) begin
                    m_end  = 1'b1;
                    m_addr = 15'd0;
                    if (!lp) m_state = 2'd3;
                end else begin
                    m_addr = m_addr + 15'd1;
                end
            end
        end
    endtask

    function automatic logic [22:0] obs();
        return {state, rom_addr, sample_out, sample_valid, song_end};
    endfunction

    function automatic logic [22:0] expv();
        return {m_state, m_addr, m_sample, m_valid, m_end};
    endfunction

    // Drive one cycle of commands from the falling edge. Advance the model
    // at the rising edge, then return at the next falling edge for sampling.
    task automatic cyc(input logic r, pl, pa, st, lp);
        rst = r; play = pl; pause = pa; stop = st; loop_en = lp;
        @(posedge clk);
        model_step(r, pl, pa, st, lp);
        @(negedge clk);
    endtask

    task automatic test_reset();
        cyc(1, 1, 0, 0, 1);
        tests++;
        if (obs() !== 23'd0) begin
            fails++; $display("FAIL reset_outputs: got %h expected 0", obs());
        end
        cyc(0, 0, 0, 0, 0);
        tests++;
        if (state !== 2'd0) begin
            fails++; $display("FAIL reset_idle_hold: got state %0d expected 0", state);
        end
    endtask

    task automatic test_play_once();
        logic [3:0] got[$];
        int         vidx[$];
        bit         seen_end = 0;
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 60 && !seen_end; i++) begin
            cyc(0, 1, 0, 0, 0);
            tests++;
            if (obs() !== expv()) begin
                fails++; $display("FAIL play_once_model cyc %0d: got %h expected %h", i, obs(), expv());
            end
            if (sample_valid) begin got.push_back(sample_out); vidx.push_back(i); end
            if (song_end) begin
                seen_end = 1;
                tests++;
                if ({state, rom_addr, sample_out} !== {2'd3, 15'd0, 4'hD}) begin
                    fails++; $display("FAIL play_once_end: got state %0d addr %0d sample %h expected 3 0 d", state, rom_addr, sample_out);
                end
            end
        end
        tests++;
        if (!seen_end || got.size() != 8) begin
            fails++; $display("FAIL play_once_count: got %0d samples end=%0d expected 8 end=1", got.size(), seen_end);
        end else begin
            for (int k = 0; k < 8; k++) begin
                tests++;
                if (got[k] !== exp_seq[k] || vidx[k] != 4 + 4 * k) begin
                    fails++; $display("FAIL play_once_seq %0d: got %h at %0d expected %h at %0d", k, got[k], vidx[k], exp_seq[k], 4 + 4 * k);
                end
            end
        end
    endtask

    task automatic test_loop();
        int nvalid = 0;
        int nend   = 0;
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 80 && nvalid < 10; i++) begin
            cyc(0, 1, 0, 0, 1);
            tests++;
            if (obs() !== expv() || state !== 2'd1) begin
                fails++; $display("FAIL loop_model cyc %0d: got %h expected %h", i, obs(), expv());
            end
            if (song_end) nend++;
            if (sample_valid) begin
                tests++;
                if (sample_out !== exp_seq[nvalid % 8]) begin
                    fails++; $display("FAIL loop_seq %0d: got %h expected %h", nvalid, sample_out, exp_seq[nvalid % 8]);
                end
                nvalid++;
            end
        end
        tests++;
        if (nvalid != 10 || nend != 1) begin
            fails++; $display("FAIL loop_counts: got %0d ticks %0d ends expected 10 ticks 1 end", nvalid, nend);
        end
    endtask

    task automatic test_pause();
        int  nvalid = 0;
        bit  resumed = 0;
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 40 && nvalid < 3; i++) begin
            cyc(0, 1, 0, 0, 0);
            if (sample_valid) nvalid++;
        end
        tests++;
        if (nvalid != 3 || sample_out !== 4'h8) begin
            fails++; $display("FAIL pause_setup: got %0d ticks sample %h expected 3 ticks sample 8", nvalid, sample_out);
        end
        for (int i = 0; i < 9; i++) begin
            cyc(0, 0, 1, 0, 0);
            tests++;
            if (state !== 2'd2 || sample_valid !== 1'b0 || sample_out !== 4'h8 || obs() !== expv()) begin
                fails++; $display("FAIL pause_hold cyc %0d: got %h expected %h", i, obs(), expv());
            end
        end
        for (int i = 0; i < 20 && !resumed; i++) begin
            cyc(0, 1, 0, 0, 0);
            if (sample_valid) begin
                resumed = 1;
                tests++;
                if (i != 4 || sample_out !== 4'h9) begin
                    fails++; $display("FAIL pause_resume: got sample %h after %0d cycles expected 9 after 4", sample_out, i);
                end
            end
        end
        tests++;
        if (!resumed) begin
            fails++; $display("FAIL pause_resume_timeout: got no sample expected one");
        end
    endtask

    task automatic test_stop_priority();
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 0);
        tests++;
        if (sample_out !== 4'hA || rom_addr !== 15'd1) begin
            fails++; $display("FAIL stop_setup: got sample %h addr %0d expected a 1", sample_out, rom_addr);
        end
        cyc(0, 1, 1, 1, 0);
        tests++;
        if (obs() !== 23'd0) begin
            fails++; $display("FAIL stop_priority: got %h expected 0", obs());
        end
    endtask

    task automatic test_pause_on_tick();
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        tests++;
        if (state !== 2'd2 || sample_valid !== 1'b0 || rom_addr !== 15'd0) begin
            fails++; $display("FAIL pause_tick_hold: got %h expected state 2 addr 0 no valid", obs());
        end
        cyc(0, 1, 0, 0, 0);
        tests++;
        if (state !== 2'd1 || sample_valid !== 1'b0) begin
            fails++; $display("FAIL pause_tick_resume: got %h expected state 1 no valid", obs());
        end
        cyc(0, 1, 0, 0, 0);
        tests++;
        if (sample_valid !== 1'b1 || sample_out !== 4'hA || rom_addr !== 15'd1) begin
            fails++; $display("FAIL pause_tick_fire: got %h expected valid sample a addr 1", obs());
        end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        bit fired = 0;
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 60 && !found; i++) begin
            cyc(0, 1, 0, 0, 0);
            if (rom_addr == 15'd5) found = 1;
        end
        tests++;
        if (!found) begin
            fails++; $display("FAIL reset_mid_setup: got addr %0d expected 5", rom_addr);
        end
        cyc(1, 1, 0, 0, 1);
        tests++;
        if (obs() !== 23'd0) begin
            fails++; $display("FAIL reset_mid_zero: got %h expected 0", obs());
        end
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
        tests++;
        if (state !== 2'd0) begin
            fails++; $display("FAIL reset_mid_idle: got state %0d expected 0", state);
        end
        for (int i = 0; i < 20 && !fired; i++) begin
            cyc(0, 1, 0, 0, 0);
            if (sample_valid) begin
                fired = 1;
                tests++;
                if (i != 4 || sample_out !== 4'hA) begin
                    fails++; $display("FAIL reset_mid_restart: got %h after %0d expected a after 4", sample_out, i);
                end
            end
        end
        tests++;
        if (!fired) begin
            fails++; $display("FAIL reset_mid_timeout: got no sample expected one");
        end
    endtask

    task automatic test_random();
        logic r, pl, pa, st, lp;
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            st = ($urandom_range(0, 39) == 0);
            pa = ($urandom_range(0, 9) == 0);
            pl = ($urandom_range(0, 3) == 0);
            lp = $urandom_range(0, 1) == 1;
            cyc(r, pl, pa, st, lp);
            tests++;
            if (obs() !== expv()) begin
                fails++; $display("FAIL random cyc %0d: got %h expected %h", i, obs(), expv());
            end
        end
    endtask

    initial begin
        rst = 1'b0; play = 1'b0; pause = 1'b0; stop = 1'b0; loop_en = 1'b0;
        m_state = 2'd0; m_addr = 15'd0; m_sample = 4'd0;
        m_valid = 1'b0; m_end = 1'b0; m_rem = c_DIV;
        @(negedge clk);
        test_reset();
        test_play_once();
        test_loop();
        test_pause();
        test_stop_priority();
        test_pause_on_tick();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
